// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the instruction fetch stage
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetch_state_t;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] PC_STEP = 32'd4;
endpackage

// File: rtl/fetch_unit_pc_register.sv
// pc_register: program counter flop with hold / +4 / redirect next-pc selection
module pc_register
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] load_pc,
  output logic [31:0] pc
);
  logic [31:0] pc_d, pc_q;
  // redirect wins over sequential advance; loaded targets are forced word-aligned
  always_comb pc_d = load ? (load_pc & ~32'd3) : step ? pc_q + PC_STEP : pc_q;
  // pc register
  always_ff @(posedge clk or posedge rst)
    if (rst) pc_q <= RESET_PC;
    else pc_q <= pc_d;
  assign pc = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with redirect squash (optional FETCH_MISALIGN_TRAP_EN)
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_misaligned
`endif
);
  fetch_state_t state_d, state_q;
  logic        squash_d, squash_q;
  logic [31:0] inst_d, inst_q, inst_pc_d, inst_pc_q;
  logic [31:0] pc;
  logic        pc_step, bad_target, trapped;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned_d, misaligned_q;
  assign bad_target = redirect_valid && |redirect_pc[1:0];
  assign trapped = misaligned_q;
  assign fetch_misaligned = misaligned_q;
  // sticky misalignment flag, updated by every redirect
  always_comb misaligned_d = redirect_valid ? bad_target : misaligned_q;
  // misalignment flag register
  always_ff @(posedge clk or posedge rst)
    if (rst) misaligned_q <= 1'b0;
    else misaligned_q <= misaligned_d;
`else
  assign bad_target = 1'b0;
  assign trapped = 1'b0;
`endif

  pc_register #(.RESET_PC(RESET_PC)) u_pc (
    .clk(clk),
    .rst(rst),
    .load(redirect_valid),
    .step(pc_step),
    .load_pc(redirect_pc),
    .pc(pc)
  );

  // next state, squash and instruction capture; redirect overrides normal progress
  always_comb begin
    state_d = state_q;
    squash_d = squash_q;
    inst_d = inst_q;
    inst_pc_d = inst_pc_q;
    pc_step = 1'b0;
    case (state_q)
      IDLE: state_d = (trapped && !redirect_valid) ? IDLE : REQ;
      REQ: if (imem_req_ready) begin
        state_d = WAIT;
        squash_d = redirect_valid;
      end
      WAIT: if (imem_rsp_valid) begin
        state_d = REQ;
        squash_d = 1'b0;
        if (!squash_q && !redirect_valid) begin
          inst_d = imem_rdata;
          inst_pc_d = pc;
          pc_step = 1'b1;
          state_d = HOLD;
        end
      end else if (redirect_valid) squash_d = 1'b1;
      HOLD: state_d = (inst_ready || redirect_valid) ? REQ : HOLD;
    endcase
    if (bad_target) begin
      state_d = IDLE;
      squash_d = 1'b0;
    end
  end

  // fsm and instruction holding registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      squash_q <= 1'b0;
      inst_q <= NOP_INST;
      inst_pc_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      squash_q <= squash_d;
      inst_q <= inst_d;
      inst_pc_q <= inst_pc_d;
    end

  assign imem_req_valid = state_q == REQ;
  assign imem_addr = pc;
  assign inst_valid = state_q == HOLD;
  assign inst = inst_q;
  assign inst_pc = inst_pc_q;
endmodule
